// File: rtl/axis_vector_source.sv
// rtl/axis_vector_source.sv - streams a buffered vector of 64-bit words and waits for a 32-bit result
module axis_vector_source #(
    parameter int DEPTH   = 16,
    parameter int TIMEOUT = 1024
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       io_wr_en,
    input  logic [$clog2(DEPTH)-1:0]   io_wr_addr,
    input  logic [63:0]                io_wr_data,
    input  logic [$clog2(DEPTH):0]     io_len,
    input  logic                       io_start,
    output logic                       io_busy,
    output logic                       io_done,
    output logic                       io_timeout,
    output logic [31:0]                io_result,
    output logic [63:0]                io_out_tdata,
    output logic                       io_out_tvalid,
    output logic                       io_out_tuser,
    output logic [7:0]                 io_out_tkeep,
    input  logic                       io_out_tready,
    output logic                       io_out_tlast,
    input  logic [31:0]                io_in_tdata,
    input  logic                       io_in_tvalid,
    output logic                       io_in_tready,
    input  logic                       io_in_tlast
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [LW-1:0] DEPTH_L = LW'(DEPTH);
    localparam logic [CW-1:0] TMAX    = CW'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, SEND, WAIT} state_t;

    state_t          state_q, state_d;
    logic [63:0]     buffer [DEPTH];
    logic [LW-1:0]   len_q;
    logic [AW-1:0]   idx_q;
    logic [AW-1:0]   idx_nx;
    logic [CW-1:0]   cnt_q;
    logic            len_ok, out_fire, in_fire, beat_last, next_last;

    assign idx_nx    = idx_q + AW'(1);
    assign len_ok    = (io_len != '0) && (io_len <= DEPTH_L);
    assign out_fire  = io_out_tvalid && io_out_tready;
    assign in_fire   = io_in_tvalid && io_in_tready;
    assign beat_last = ({1'b0, idx_q} + LW'(1)) == len_q;
    assign next_last = ({1'b0, idx_q} + LW'(2)) == len_q;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (io_start && len_ok) state_d = SEND;
            SEND: if (out_fire && beat_last) state_d = WAIT;
            // A closing result beat wins over an expiring counter.
            WAIT: if ((in_fire && io_in_tlast) || cnt_q == TMAX) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Buffer is deliberately outside the reset domain so contents survive reset.
    always_ff @(posedge clock) begin
        if (!reset && state_q == IDLE && io_wr_en)
            buffer[io_wr_addr] <= io_wr_data;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= IDLE;
            len_q         <= '0;
            idx_q         <= '0;
            cnt_q         <= '0;
            io_busy       <= 1'b0;
            io_done       <= 1'b0;
            io_timeout    <= 1'b0;
            io_result     <= '0;
            io_out_tdata  <= '0;
            io_out_tvalid <= 1'b0;
            io_out_tuser  <= 1'b0;
            io_out_tkeep  <= 8'hFF;
            io_out_tlast  <= 1'b0;
            io_in_tready  <= 1'b0;
        end else begin
            state_q       <= state_d;
            io_busy       <= state_d != IDLE;
            io_out_tvalid <= state_d == SEND;
            io_in_tready  <= state_d == WAIT;
            io_out_tkeep  <= 8'hFF;
            io_done       <= 1'b0;
            io_timeout    <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (state_d == SEND) begin
                        len_q        <= io_len;
                        idx_q        <= '0;
                        io_out_tdata <= buffer[0];
                        io_out_tuser <= 1'b1;
                        io_out_tlast <= io_len == LW'(1);
                    end
                end
                SEND: begin
                    if (out_fire) begin
                        if (beat_last) begin
                            cnt_q        <= '0;
                            io_out_tuser <= 1'b0;
                            io_out_tlast <= 1'b0;
                        end else begin
                            idx_q        <= idx_nx;
                            io_out_tdata <= buffer[idx_nx];
                            io_out_tuser <= 1'b0;
                            io_out_tlast <= next_last;
                        end
                    end
                end
                WAIT: begin
                    cnt_q <= cnt_q + CW'(1);
                    if (in_fire && io_in_tlast) begin
                        io_result <= io_in_tdata;
                        io_done   <= 1'b1;
                    end else if (cnt_q == TMAX) begin
                        io_timeout <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_axis_vector_source.sv
// tb/tb_axis_vector_source.sv - directed checks of the vector source stream, result wait and timeout
module tb_axis_vector_source;
    localparam int DEPTH   = 16;
    localparam int TIMEOUT = 32;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        io_wr_en = 1'b0;
    logic [3:0]  io_wr_addr = '0;
    logic [63:0] io_wr_data = '0;
    logic [4:0]  io_len = '0;
    logic        io_start = 1'b0;
    logic        io_busy, io_done, io_timeout;
    logic [31:0] io_result;
    logic [63:0] io_out_tdata;
    logic        io_out_tvalid, io_out_tuser, io_out_tlast;
    logic [7:0]  io_out_tkeep;
    logic        io_out_tready = 1'b0;
    logic [31:0] io_in_tdata = '0;
    logic        io_in_tvalid = 1'b0;
    logic        io_in_tready;
    logic        io_in_tlast = 1'b0;

    int errors = 0;
    int checks = 0;
    int done_cnt = 0, tmo_cnt = 0, hs_cnt = 0, overlap = 0;
    int base, beat;
    logic [63:0] exp_buf [DEPTH];

    axis_vector_source #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
        .clock(clock), .reset(reset),
        .io_wr_en(io_wr_en), .io_wr_addr(io_wr_addr), .io_wr_data(io_wr_data),
        .io_len(io_len), .io_start(io_start),
        .io_busy(io_busy), .io_done(io_done), .io_timeout(io_timeout), .io_result(io_result),
        .io_out_tdata(io_out_tdata), .io_out_tvalid(io_out_tvalid), .io_out_tuser(io_out_tuser),
        .io_out_tkeep(io_out_tkeep), .io_out_tready(io_out_tready), .io_out_tlast(io_out_tlast),
        .io_in_tdata(io_in_tdata), .io_in_tvalid(io_in_tvalid), .io_in_tready(io_in_tready),
        .io_in_tlast(io_in_tlast)
    );

    always #5 clock = ~clock;

    always @(posedge clock) begin
        if (io_done) done_cnt++;
        if (io_timeout) tmo_cnt++;
        if (io_done && io_timeout) overlap++;
        if (io_out_tvalid && io_out_tready) hs_cnt++;
    end

    task automatic tick();
        @(negedge clock);
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic start(input logic [4:0] len);
        io_len = len;
        io_start = 1'b1;
        tick();
        io_start = 1'b0;
    endtask

    task automatic respond(input logic [31:0] data, input logic last);
        io_in_tdata = data;
        io_in_tlast = last;
        io_in_tvalid = 1'b1;
        tick();
        io_in_tvalid = 1'b0;
        io_in_tlast = 1'b0;
    endtask

    initial begin
        tick();
        tick();
        chk("rst_busy", io_busy, 1'b0);
        chk("rst_tvalid", io_out_tvalid, 1'b0);
        chk("rst_tkeep", io_out_tkeep, 8'hFF);
        chk("rst_in_tready", io_in_tready, 1'b0);
        chk("rst_result", io_result, 32'h0);
        chk("rst_tdata", io_out_tdata, 64'h0);
        chk("rst_done", io_done, 1'b0);
        reset = 1'b0;

        for (int i = 0; i < DEPTH; i++) begin
            exp_buf[i] = (i == 0) ? 64'h3 : (i == 1) ? 64'h4 : 64'hA5A5_0000_0000_0000 + 64'(i * 17);
            io_wr_en = 1'b1;
            io_wr_addr = 4'(i);
            io_wr_data = exp_buf[i];
            tick();
        end
        io_wr_en = 1'b0;

        // Two back-to-back beats then a direct result
        io_out_tready = 1'b1;
        base = done_cnt;
        start(5'd2);
        chk("b0_tvalid", io_out_tvalid, 1'b1);
        chk("b0_tdata", io_out_tdata, 64'h3);
        chk("b0_tuser", io_out_tuser, 1'b1);
        chk("b0_tlast", io_out_tlast, 1'b0);
        chk("b0_busy", io_busy, 1'b1);
        tick();
        chk("b1_tdata", io_out_tdata, 64'h4);
        chk("b1_tuser", io_out_tuser, 1'b0);
        chk("b1_tlast", io_out_tlast, 1'b1);
        tick();
        chk("wait_tvalid", io_out_tvalid, 1'b0);
        chk("wait_in_tready", io_in_tready, 1'b1);
        respond(32'h5, 1'b1);
        chk("r5_done", io_done, 1'b1);
        chk("r5_result", io_result, 32'h5);
        chk("r5_busy", io_busy, 1'b0);
        tick();
        chk("r5_done_low", io_done, 1'b0);
        chk("r5_done_once", done_cnt - base, 1);

        // Stalled stream: tready pattern 1,0,0,1,0,0,...
        io_out_tready = 1'b0;
        base = hs_cnt;
        beat = 0;
        start(5'd4);
        for (int i = 0; i < 40 && !io_in_tready; i++) begin
            chk("st_tvalid", io_out_tvalid, 1'b1);
            chk("st_tdata", io_out_tdata, exp_buf[beat]);
            chk("st_tlast", io_out_tlast, beat == 3);
            chk("st_tuser", io_out_tuser, beat == 0);
            io_out_tready = (i % 3 == 0);
            if (io_out_tready) beat++;
            tick();
        end
        io_out_tready = 1'b0;
        chk("st_reached_wait", io_in_tready, 1'b1);
        chk("st_handshakes", hs_cnt - base, 4);
        respond(32'h11, 1'b1);
        chk("r11_result", io_result, 32'h11);

        // Timeout with no response
        io_out_tready = 1'b1;
        base = tmo_cnt;
        start(5'd1);
        tick();
        for (int i = 0; i < TIMEOUT - 1; i++) tick();
        chk("tmo_not_yet", io_timeout, 1'b0);
        chk("tmo_busy_before", io_busy, 1'b1);
        tick();
        chk("tmo_pulse", io_timeout, 1'b1);
        chk("tmo_busy_after", io_busy, 1'b0);
        chk("tmo_result_kept", io_result, 32'h11);
        tick();
        chk("tmo_pulse_low", io_timeout, 1'b0);
        chk("tmo_once", tmo_cnt - base, 1);

        // Result arriving on the final wait cycle counts as done
        base = tmo_cnt;
        start(5'd1);
        tick();
        for (int i = 0; i < TIMEOUT - 1; i++) tick();
        respond(32'h22, 1'b1);
        chk("edge_done", io_done, 1'b1);
        chk("edge_no_tmo", io_timeout, 1'b0);
        chk("edge_result", io_result, 32'h22);
        tick();
        chk("edge_tmo_cnt", tmo_cnt - base, 0);

        // Illegal lengths ignored
        base = hs_cnt;
        start(5'd0);
        chk("len0_tvalid", io_out_tvalid, 1'b0);
        chk("len0_busy", io_busy, 1'b0);
        start(5'd17);
        chk("len17_tvalid", io_out_tvalid, 1'b0);
        chk("len17_busy", io_busy, 1'b0);
        tick();
        chk("bad_len_no_hs", hs_cnt - base, 0);

        // Start and write during SEND ignored
        io_out_tready = 1'b0;
        start(5'd8);
        io_len = 5'd2;
        io_start = 1'b1;
        io_wr_en = 1'b1;
        io_wr_addr = 4'd0;
        io_wr_data = 64'hDEAD_BEEF_DEAD_BEEF;
        tick();
        io_start = 1'b0;
        io_wr_en = 1'b0;
        chk("ign_tvalid", io_out_tvalid, 1'b1);
        chk("ign_tdata", io_out_tdata, exp_buf[0]);
        base = hs_cnt;
        io_out_tready = 1'b1;
        for (int i = 0; i < 20 && !io_in_tready; i++) tick();
        io_out_tready = 1'b0;
        chk("ign_handshakes", hs_cnt - base, 8);

        // Non-last result beat discarded, last one captured
        base = done_cnt;
        respond(32'h7, 1'b0);
        chk("r7_no_done", io_done, 1'b0);
        chk("r7_result_kept", io_result, 32'h22);
        chk("r7_busy", io_busy, 1'b1);
        respond(32'h9, 1'b1);
        chk("r9_done", io_done, 1'b1);
        chk("r9_result", io_result, 32'h9);
        tick();
        chk("r9_done_once", done_cnt - base, 1);

        // Reset while the third beat is presented
        base = done_cnt + tmo_cnt;
        io_out_tready = 1'b1;
        start(5'd8);
        tick();
        tick();
        chk("rs_beat2", io_out_tdata, exp_buf[2]);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("rs_tvalid", io_out_tvalid, 1'b0);
        chk("rs_busy", io_busy, 1'b0);
        tick();
        chk("rs_no_pulse", done_cnt + tmo_cnt - base, 0);
        start(5'd1);
        chk("rr_tdata", io_out_tdata, 64'h3);
        chk("rr_tuser", io_out_tuser, 1'b1);
        chk("rr_tlast", io_out_tlast, 1'b1);
        tick();
        chk("rr_wait", io_in_tready, 1'b1);
        respond(32'h33, 1'b1);
        chk("rr_result", io_result, 32'h33);
        tick();
        chk("never_overlap", overlap, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
